// File: rtl/drop_control_if.sv
// drop_control_if: column/load request inputs and block-draw outputs of the Connect Four sequencer
// master = stimulus side (drives col_sel/load), slave = sequencer (drives draw/status outputs)
interface drop_control_if;
  logic [2:0] col_sel;
  logic       load;
  logic [3:0] pixel_count;
  logic [2:0] location;
  logic [2:0] decoded_height;
  logic       go;
  logic       player;
  logic       plot;
  logic       busy;
  logic       column_full;
  logic       board_full;
  modport master (
    output col_sel, load,
    input  pixel_count, location, decoded_height, go, player, plot, busy, column_full, board_full
  );
  modport slave (
    input  col_sel, load,
    output pixel_count, location, decoded_height, go, player, plot, busy, column_full, board_full
  );
endinterface

// File: rtl/drop_control.sv
// drop_control: Connect Four move sequencer feeding one 16-pixel block draw per move to the VGA datapath
// Ports: clk, resetn (async active-low); bus.slave carries col_sel/load in and
// pixel_count/location/decoded_height/go/player/plot/busy/column_full/board_full out.
module drop_control #(
  parameter int NUM_COLS = 7,
  parameter int NUM_ROWS = 6,
  parameter int NUM_PIX  = 16
) (
  input logic          clk,
  input logic          resetn,
  drop_control_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_COMMIT, S_RELEASE} state_t;
  state_t              state_q, state_d;
  logic [NUM_ROWS-1:0] therm_q [NUM_COLS];
  logic [NUM_ROWS-1:0] therm_d [NUM_COLS];
  logic [5:0]          moves_q, moves_d;
  logic [3:0]          pix_q, pix_d;
  logic [2:0]          loc_q, loc_d, hgt_q, hgt_d;
  logic                go_q, go_d, player_q, player_d, plot_q, plot_d;
  logic                busy_q, busy_d, cfull_q, cfull_d, bfull_q, bfull_d;
  logic                load_q;
  logic                req, col_ok;
  logic [NUM_ROWS-1:0] sel_therm;
  logic [2:0]          sel_height;
  // only the rising edge of load starts a move, so holding load gives one move
  assign req    = bus.load & ~load_q;
  assign col_ok = int'(bus.col_sel) < NUM_COLS;
  // thermometer column height -> row index of the next free slot
  always_comb begin
    sel_therm = '0;
    for (int c = 0; c < NUM_COLS; c++) sel_therm = (bus.col_sel == 3'(c)) ? therm_q[c] : sel_therm;
    sel_height = '0;
    for (int r = 0; r < NUM_ROWS; r++) sel_height = sel_height + 3'(sel_therm[r]);
  end
  always_comb begin
    state_d  = state_q;
    therm_d  = therm_q;
    moves_d  = moves_q;
    pix_d    = pix_q;
    loc_d    = loc_q;
    hgt_d    = hgt_q;
    go_d     = go_q;
    player_d = player_q;
    busy_d   = busy_q;
    cfull_d  = 1'b0;
    bfull_d  = bfull_q;
    plot_d   = state_q == S_DRAW;
    case (state_q)
      S_IDLE: begin
        if (req && !bfull_q) begin
          if (!col_ok || sel_therm[NUM_ROWS-1]) begin
            cfull_d = 1'b1;
            state_d = S_RELEASE;
          end else begin
            loc_d   = bus.col_sel;
            hgt_d   = sel_height;
            go_d    = 1'b1;
            busy_d  = 1'b1;
            pix_d   = '0;
            state_d = S_DRAW;
          end
        end
      end
      S_DRAW: begin
        pix_d = pix_q + 4'd1;
        if (pix_q == 4'(NUM_PIX - 1)) begin
          pix_d   = '0;
          go_d    = 1'b0;
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        for (int c = 0; c < NUM_COLS; c++)
          therm_d[c] = (loc_q == 3'(c)) ? {therm_q[c][NUM_ROWS-2:0], 1'b1} : therm_q[c];
        moves_d  = moves_q + 6'd1;
        player_d = ~player_q;
        bfull_d  = bfull_q | (moves_d == 6'(NUM_COLS * NUM_ROWS));
        state_d  = S_RELEASE;
      end
      S_RELEASE: begin
        if (!bus.load) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      for (int c = 0; c < NUM_COLS; c++) therm_q[c] <= '0;
      moves_q  <= '0;
      pix_q    <= '0;
      loc_q    <= '0;
      hgt_q    <= '0;
      go_q     <= 1'b0;
      player_q <= 1'b0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      cfull_q  <= 1'b0;
      bfull_q  <= 1'b0;
      load_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      therm_q  <= therm_d;
      moves_q  <= moves_d;
      pix_q    <= pix_d;
      loc_q    <= loc_d;
      hgt_q    <= hgt_d;
      go_q     <= go_d;
      player_q <= player_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      cfull_q  <= cfull_d;
      bfull_q  <= bfull_d;
      load_q   <= bus.load;
    end
  end
  assign bus.pixel_count    = pix_q;
  assign bus.location       = loc_q;
  assign bus.decoded_height = hgt_q;
  assign bus.go             = go_q;
  assign bus.player         = player_q;
  assign bus.plot           = plot_q;
  assign bus.busy           = busy_q;
  assign bus.column_full    = cfull_q;
  assign bus.board_full     = bfull_q;
endmodule

// File: tb/tb_drop_control.sv
// tb_drop_control: directed table, reset-mid-draw sequence and random game checked against a board model
module tb_drop_control;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  drop_control_if bus();
  drop_control dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_bad = 0;
  int h[7];
  int moves;
  bit pl, bf;
  typedef struct {
    int col;
    int hold;
    bit draw;
    int hgt;
    bit pl;
    bit cf;
  } vec_t;
  vec_t vecs[$];
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic model_reset();
    foreach (h[c]) h[c] = 0;
    moves = 0;
    pl = 1'b0;
    bf = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    bus.load = 1'b0;
    bus.col_sel = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask
  // one request: load held for `hold` rising edges, col_sel scrambled mid-draw
  task automatic drop(input int col, input int hold, input bit draw, input int hgt,
                      input bit plr, input bit cf, input bit bf_exp);
    int n_go = 0, n_plot = 0, n_cf = 0, f_err = 0, lag_err = 0, pl0 = 0;
    bit prev_go = 1'b0;
    @(negedge clk);
    bus.col_sel = 3'(col);
    bus.load = 1'b1;
    for (int i = 0; i < hold + 24; i++) begin
      @(negedge clk);
      if (i == 0) pl0 = int'(bus.player);
      if (bus.go) begin
        if (int'(bus.pixel_count) != n_go || int'(bus.location) != col ||
            int'(bus.decoded_height) != hgt || bus.player != plr || !bus.busy) f_err++;
        n_go++;
      end
      if (bus.plot != prev_go) lag_err++;
      prev_go = bus.go;
      n_plot += int'(bus.plot);
      n_cf += int'(bus.column_full);
      if (i == hold - 1) bus.load = 1'b0;
      if (i == 5) bus.col_sel = 3'((col + 3) % 8);
    end
    check("go_cycles", n_go, draw ? 16 : 0);
    check("plot_cycles", n_plot, draw ? 16 : 0);
    check("column_full_pulses", n_cf, int'(cf));
    check("draw_fields_errs", f_err, 0);
    check("plot_lag_errs", lag_err, 0);
    check("player_before", pl0, int'(plr));
    check("player_after", int'(bus.player), int'(plr ^ draw));
    check("board_full", int'(bus.board_full), int'(bf_exp));
    check("busy_idle", int'(bus.busy), 0);
  endtask
  task automatic play(input int col, input int hold);
    bit legal, rej, bfe;
    int hg;
    legal = !bf && col < 7 && h[col % 7] < 6;
    rej = !bf && !legal;
    hg = (col < 7) ? h[col] : 0;
    bfe = bf || (legal && moves + 1 == 42);
    drop(col, hold, legal, hg, pl, rej, bfe);
    if (legal) begin
      h[col]++;
      moves++;
      pl = ~pl;
      bf = bfe;
    end
  endtask
  initial begin
    bit found;
    bus.load = 1'b0;
    bus.col_sel = '0;
    vecs.push_back('{3, 1, 1'b1, 0, 1'b0, 1'b0});
    for (int k = 0; k < 6; k++) vecs.push_back('{2, 1, 1'b1, k, (k % 2 == 0), 1'b0});
    vecs.push_back('{2, 1, 1'b0, 0, 1'b1, 1'b1});
    vecs.push_back('{7, 1, 1'b0, 0, 1'b1, 1'b1});
    vecs.push_back('{0, 40, 1'b1, 0, 1'b1, 1'b0});
    vecs.push_back('{0, 2, 1'b1, 1, 1'b0, 1'b0});
    repeat (2) @(negedge clk);
    check("rst_pixel_count", int'(bus.pixel_count), 0);
    check("rst_location", int'(bus.location), 0);
    check("rst_height", int'(bus.decoded_height), 0);
    check("rst_go", int'(bus.go), 0);
    check("rst_player", int'(bus.player), 0);
    check("rst_plot", int'(bus.plot), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_column_full", int'(bus.column_full), 0);
    check("rst_board_full", int'(bus.board_full), 0);
    resetn = 1'b1;
    model_reset();
    foreach (vecs[i]) drop(vecs[i].col, vecs[i].hold, vecs[i].draw, vecs[i].hgt, vecs[i].pl, vecs[i].cf, 1'b0);
    // reset in the middle of a draw
    do_reset();
    play(4, 1);
    @(negedge clk);
    bus.col_sel = 3'd4;
    bus.load = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      found = bus.go && bus.pixel_count == 4'd8;
    end
    check("reach_pixel8", int'(found), 1);
    #2 resetn = 1'b0;
    #1;
    check("async_plot", int'(bus.plot), 0);
    check("async_go", int'(bus.go), 0);
    check("async_busy", int'(bus.busy), 0);
    check("async_player", int'(bus.player), 0);
    @(negedge clk);
    bus.load = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    play(4, 1);
    play(4, 1);
    // random game to a full board, then requests must be ignored
    do_reset();
    for (int i = 0; i < 150 && moves < 42; i++) play(int'($urandom_range(0, 7)), int'($urandom_range(1, 3)));
    for (int c = 0; c < 7; c++) while (h[c] < 6) play(c, 1);
    check("model_moves", moves, 42);
    play(0, 1);
    play(7, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
